partsel_down_stream: RTL and testbench

Serializer that accepts one packed word declared `[MSB:LSB]` (either endianness, negative indices allowed) and emits it as a stream of `W`-bit windows. Each window is the SystemVerilog descending indexed part-select `word[idx -: W]`, with `idx` walking from the highest numeric index down to the lowest. It sits directly upstream of the descending part-select consumers and produces their `(data, sel)` pairs, one window per valid/ready handshake.

---
 rtl/partsel_down_stream.sv | 81 ++++++++
 tb/tb_partsel_down_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/partsel_down_stream.sv
// Serializes one packed word [MSB:LSB] into W-bit windows word[idx -: W],
// walking idx from the highest numeric index down to the lowest.
module partsel_down_stream #(
    parameter int MSB = 0,
    parameter int LSB = 0,
    parameter int W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSB:LSB]      in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic signed [31:0]  out_idx,
    output logic                out_last
);

    localparam int HI  = (MSB > LSB) ? MSB : LSB;
    localparam int LO  = (MSB > LSB) ? LSB : MSB;
    localparam int N   = HI - LO + 1;
    localparam bit BIG = (MSB < LSB);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state;
    logic [N-1:0]       word;
    logic [N-1:0]       word_in;
    logic signed [31:0] idx;
    logic [N+W-1:0]     pad;
    logic [31:0]        sh;
    logic [W-1:0]       slice;

    // word[k] always holds element LO+k, whatever the declared direction
    for (genvar k = 0; k < N; k++) begin : g_norm
        assign word_in[k] = in_data[LO+k];
    end

    // W zero bits below element LO supply the lanes that fall under LO
    assign pad   = {word, {W{1'b0}}};
    assign sh    = idx - LO + 1;
    assign slice = W'(pad >> sh);

    // slice[W-1] is element idx; big-endian words put it in lane 0 instead
    for (genvar j = 0; j < W; j++) begin : g_lane
        assign out_data[j] = BIG ? slice[W-1-j] : slice[j];
    end

    assign out_valid = (state == STREAM);
    assign out_idx   = idx;
    assign out_last  = (state == STREAM) && (idx - W < LO);
    assign in_ready  = !rst && !flush && ((state == IDLE) || (out_last && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= HI;
            word  <= '0;
        end else if (flush) begin
            state <= IDLE;
            idx   <= HI;
        end else begin
            if (state == STREAM && out_ready) begin
                if (out_last) begin
                    state <= IDLE;
                    idx   <= HI;
                end else begin
                    idx <= idx - W;
                end
            end
            if (in_valid && in_ready) begin
                word  <= word_in;
                idx   <= HI;
                state <= STREAM;
            end
        end
    end

endmodule

// File: tb/tb_partsel_down_stream.sv
// Bench for partsel_down_stream: four instances (LE partial, BE partial,
// exact fit, W=3) checked every cycle against a window-level model.
module tb_partsel_down_stream;

    localparam int PM[4] = '{4, 0, 7, 6};
    localparam int PL[4] = '{-2, 6, 2, 0};
    localparam int PW[4] = '{2, 2, 2, 3};

    typedef struct {
        int g;
        int kind;
        int idx;
        int data;
        int last;
        int cyc;
    } ev_t;

    logic               clk;
    logic               rst[4], flush[4], ivld[4], irdy[4], ovld[4], ordy[4], olast[4];
    logic [31:0]        din[4], od[4];
    logic signed [31:0] oi[4];

    bit          mact[4];
    int          midx[4];
    logic [31:0] mword[4];
    bit          en;
    int          checks, errors, cyc;
    ev_t         cap[$];

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int M  = PM[g];
        localparam int L  = PL[g];
        localparam int WW = PW[g];
        localparam int NN = ((M > L) ? M - L : L - M) + 1;
        logic [NN-1:0] din_l;
        logic [WW-1:0] od_l;
        assign din_l = din[g][NN-1:0];
        assign od[g] = 32'(od_l);
        partsel_down_stream #(.MSB(M), .LSB(L), .W(WW)) dut (
            .clk(clk), .rst(rst[g]), .flush(flush[g]),
            .in_valid(ivld[g]), .in_ready(irdy[g]), .in_data(din_l),
            .out_valid(ovld[g]), .out_ready(ordy[g]), .out_data(od_l),
            .out_idx(oi[g]), .out_last(olast[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hi(int g);
        return (PM[g] > PL[g]) ? PM[g] : PL[g];
    endfunction

    function automatic int lo(int g);
        return (PM[g] > PL[g]) ? PL[g] : PM[g];
    endfunction

    // word bit at declared index i: the rightmost declared bit is bit 0 of din
    function automatic int wbit(int g, logic [31:0] w, int i);
        int pos;
        if (i < lo(g)) return 0;
        pos = (PM[g] >= PL[g]) ? i - PL[g] : PL[g] - i;
        return ((w >> pos) & 32'd1) != 0 ? 1 : 0;
    endfunction

    // word[idx -: W]: LE puts element idx-t in lane W-1-t, BE puts it in lane t
    function automatic int expwin(int g, logic [31:0] w, int idx);
        int r = 0;
        for (int t = 0; t < PW[g]; t++) begin
            int lane = (PM[g] >= PL[g]) ? PW[g] - 1 - t : t;
            if (wbit(g, w, idx - t) != 0) r = r | (1 << lane);
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            bit last, hs, acc;
            last = mact[g] && (midx[g] - PW[g] < lo(g));
            hs   = mact[g] && ordy[g];
            acc  = ivld[g] && (!mact[g] || (hs && last));
            if (rst[g] || flush[g]) begin
                mact[g] <= 0;
                midx[g] <= hi(g);
            end else begin
                if (hs && !last) midx[g] <= midx[g] - PW[g];
                if (hs && last)  mact[g] <= 0;
                if (acc) begin
                    mword[g] <= din[g];
                    midx[g]  <= hi(g);
                    mact[g]  <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            for (int g = 0; g < 4; g++) begin
                int  exr, exl;
                ev_t e;
                exl = (mact[g] && (midx[g] - PW[g] < lo(g))) ? 1 : 0;
                exr = (!rst[g] && !flush[g] && (!mact[g] || (exl != 0 && ordy[g]))) ? 1 : 0;
                chk($sformatf("g%0d_in_ready", g), int'(irdy[g]), exr);
                chk($sformatf("g%0d_out_valid", g), int'(ovld[g]), int'(mact[g]));
                chk($sformatf("g%0d_out_last", g), int'(olast[g]), exl);
                if (mact[g]) begin
                    chk($sformatf("g%0d_out_idx", g), oi[g], midx[g]);
                    chk($sformatf("g%0d_out_data", g), int'(od[g]), expwin(g, mword[g], midx[g]));
                end
                if (ovld[g] && ordy[g] && !rst[g] && !flush[g]) begin
                    e.g = g; e.kind = 0; e.idx = oi[g]; e.data = int'(od[g]);
                    e.last = int'(olast[g]); e.cyc = cyc;
                    cap.push_back(e);
                end
                if (ivld[g] && irdy[g]) begin
                    e.g = g; e.kind = 1; e.idx = 0; e.data = 0; e.last = 0; e.cyc = cyc;
                    cap.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wins(string nm, int g, int n, int ei[8], int ed[8], int el[8]);
        ev_t w[$];
        foreach (cap[i]) if (cap[i].g == g && cap[i].kind == 0) w.push_back(cap[i]);
        chk($sformatf("%s_count", nm), w.size(), n);
        for (int i = 0; i < n && i < w.size(); i++) begin
            chk($sformatf("%s_idx%0d", nm, i), w[i].idx, ei[i]);
            chk($sformatf("%s_data%0d", nm, i), w[i].data, ed[i]);
            chk($sformatf("%s_last%0d", nm, i), w[i].last, el[i]);
        end
    endtask

    initial begin
        ev_t wd[$];
        ev_t ad[$];
        bit  acc;
        checks = 0; errors = 0; cyc = 0; en = 0;
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1; flush[g] = 0; ivld[g] = 0; ordy[g] = 0; din[g] = '0;
            mact[g] = 0; midx[g] = hi(g); mword[g] = '0;
        end
        step();
        en = 1;
        step();
        for (int g = 0; g < 4; g++) rst[g] = 0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_g%0d_valid", g), int'(ovld[g]), 0);
            chk($sformatf("rst_g%0d_last", g), int'(olast[g]), 0);
            chk($sformatf("rst_g%0d_data", g), int'(od[g]), 0);
            chk($sformatf("rst_g%0d_idx", g), oi[g], hi(g));
            chk($sformatf("rst_g%0d_ready", g), int'(irdy[g]), 1);
        end

        // little-endian [4:-2] and big-endian [0:6], both with a partial last beat
        din[0] = 32'b1011001; din[1] = 32'b1100101;
        ivld[0] = 1; ivld[1] = 1; ordy[0] = 1; ordy[1] = 1;
        step();
        ivld[0] = 0; ivld[1] = 0;
        repeat (6) step();
        check_wins("le", 0, 4, '{4, 2, 0, -2, 0, 0, 0, 0}, '{2, 3, 0, 2, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});
        check_wins("be", 1, 4, '{6, 4, 2, 0, 0, 0, 0, 0}, '{1, 1, 2, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});
        cap.delete();

        // exact fit [7:2] with out_ready stalls
        din[2] = 32'b110100; ivld[2] = 1; ordy[2] = 1;
        step();
        ivld[2] = 0;
        for (int i = 0; i < 8; i++) begin
            int pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
            ordy[2] = pat[i][0];
            step();
        end
        check_wins("stall", 2, 3, '{7, 5, 3, 0, 0, 0, 0, 0}, '{3, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 0, 0});
        cap.delete();

        // back-to-back words on [6:0], W=3
        din[3] = 32'h55; ivld[3] = 1; ordy[3] = 1;
        step();
        din[3] = 32'h2A;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = irdy[3];
            step();
        end
        if (!acc) chk("b2b_accept_timeout", 0, 1);
        ivld[3] = 0;
        repeat (5) step();
        check_wins("b2b", 3, 6, '{6, 3, 0, 6, 3, 0, 0, 0}, '{5, 2, 4, 2, 5, 0, 0, 0}, '{0, 0, 1, 0, 0, 1, 0, 0});
        foreach (cap[i]) if (cap[i].g == 3) begin
            if (cap[i].kind == 0) wd.push_back(cap[i]);
            else ad.push_back(cap[i]);
        end
        chk("b2b_accepts", ad.size(), 2);
        if (wd.size() == 6 && ad.size() == 2) begin
            chk("b2b_second_accept_cycle", ad[1].cyc, wd[2].cyc);
            for (int i = 1; i < 6; i++) chk($sformatf("b2b_gap%0d", i), wd[i].cyc - wd[i-1].cyc, 1);
        end
        cap.delete();

        // flush on the second window of word A, with a handshake and an offer pending
        din[0] = 32'b0110110; ivld[0] = 1; ordy[0] = 1;
        step();
        ivld[0] = 0;
        step();
        flush[0] = 1; ivld[0] = 1; din[0] = 32'b1001110;
        step();
        flush[0] = 0;
        #1;
        chk("flush_valid", int'(ovld[0]), 0);
        chk("flush_idx", oi[0], 4);
        step();
        ivld[0] = 0;
        repeat (5) step();
        check_wins("flush", 0, 5, '{4, 4, 2, 0, -2, 0, 0, 0}, '{1, 2, 1, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 0, 0});
        cap.delete();

        // synchronous reset during the second window
        din[0] = 32'b1011001; ivld[0] = 1;
        step();
        ivld[0] = 0;
        step();
        rst[0] = 1;
        #1;
        chk("rst_mid_ready_low", int'(irdy[0]), 0);
        step();
        rst[0] = 0;
        #1;
        chk("rst_mid_valid", int'(ovld[0]), 0);
        chk("rst_mid_idx", oi[0], 4);
        chk("rst_mid_data", int'(od[0]), 0);
        chk("rst_mid_last", int'(olast[0]), 0);
        chk("rst_mid_ready_high", int'(irdy[0]), 1);
        repeat (4) step();
        check_wins("rst_mid", 0, 1, '{4, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
